// File: rtl/signal_debouncer.sv
// Two-flop synchronizer followed by a four-state debounce FSM with a stability counter.
// Optional rejected-transition counter (glitch_cnt) is built when GLITCH_COUNT_EN is defined.
module signal_debouncer #(
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       signal_in,
  output logic       signal_out,
  output logic       busy
`ifdef GLITCH_COUNT_EN
  ,
  output logic [7:0] glitch_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    RISE_WAIT = 2'd1,
    HIGH      = 2'd2,
    FALL_WAIT = 2'd3
  } state_e;

  logic             sync1_q, sync1_d;
  logic             sync_q, sync_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Synchronizer stages: only sync_q is allowed to influence the FSM.
  always_comb begin
    sync1_d = signal_in;
    sync_d  = sync1_q;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync_q  <= 1'b0;
      state_q <= LOW;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and stability counter; an opposite sample in a WAIT state aborts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      LOW: begin
        if (sync_q) begin
          state_d = RISE_WAIT;
          cnt_d   = '0;
        end
      end
      RISE_WAIT: begin
        if (!sync_q) begin
          state_d = LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HIGH: begin
        if (!sync_q) begin
          state_d = FALL_WAIT;
          cnt_d   = '0;
        end
      end
      FALL_WAIT: begin
        if (sync_q) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decoded straight from the state register.
  always_comb begin
    signal_out = 1'b0;
    busy       = 1'b0;
    case (state_q)
      RISE_WAIT: busy = 1'b1;
      HIGH:      signal_out = 1'b1;
      FALL_WAIT: begin
        signal_out = 1'b1;
        busy       = 1'b1;
      end
      default: begin
        signal_out = 1'b0;
        busy       = 1'b0;
      end
    endcase
  end

`ifdef GLITCH_COUNT_EN
  logic       abort_c;
  logic [7:0] glitch_cnt_q, glitch_cnt_d;

  // Saturating count of aborted qualifications.
  always_comb begin
    abort_c      = ((state_q == RISE_WAIT) && !sync_q) ||
                   ((state_q == FALL_WAIT) && sync_q);
    glitch_cnt_d = glitch_cnt_q;
    if (abort_c && (glitch_cnt_q != 8'hFF)) begin
      glitch_cnt_d = glitch_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      glitch_cnt_q <= 8'd0;
    end else begin
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

  assign glitch_cnt = glitch_cnt_q;
`endif

endmodule

// File: tb/tb_signal_debouncer.sv
// Scoreboard bench for signal_debouncer: a run-length reference model pushes the expected
// outputs for every clock edge and an independent monitor pops and compares them.
module tb_signal_debouncer;

  localparam int unsigned S = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       signal_in;
  logic       signal_out;
  logic       busy;
`ifdef GLITCH_COUNT_EN
  logic [7:0] glitch_cnt;
`endif

  signal_debouncer #(.STABLE_CYCLES(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .signal_in  (signal_in),
    .signal_out (signal_out),
    .busy       (busy)
`ifdef GLITCH_COUNT_EN
    ,
    .glitch_cnt (glitch_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       out;
    logic       busy;
    logic [7:0] gcnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: a new level is accepted once the synchronized input has differed from
  // the output for STABLE_CYCLES+1 consecutive samples; a shorter run is a rejected glitch.
  logic dly[2];
  logic m_out;
  int   m_run;
  int   m_gcnt;

  always @(posedge clk) begin
    logic sample;
    exp_t e;
    if (rst) begin
      dly[0] = 1'b0;
      dly[1] = 1'b0;
      m_out  = 1'b0;
      m_run  = 0;
      m_gcnt = 0;
    end else begin
      sample = dly[1];
      if (sample != m_out) begin
        m_run = m_run + 1;
        if (m_run == S + 1) begin
          m_out = ~m_out;
          m_run = 0;
        end
      end else if (m_run > 0) begin
        m_run = 0;
        if (m_gcnt < 255) m_gcnt = m_gcnt + 1;
      end
      dly[1] = dly[0];
      dly[0] = signal_in;
    end
    e.out  = m_out;
    e.busy = (m_run > 0);
    e.gcnt = 8'(m_gcnt);
    exp_q.push_back(e);
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  // Monitor: one expected entry per edge, compared just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() == 0) begin
      chk("queue_underflow", 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk("signal_out", int'(signal_out === 1'b1), int'(e.out));
      chk("busy", int'(busy === 1'b1), int'(e.busy));
`ifdef GLITCH_COUNT_EN
      chk("glitch_cnt", int'(glitch_cnt), int'(e.gcnt));
`endif
    end
  end

  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      signal_in = v;
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 1; i < n; i++) @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    signal_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Clean rise, then a 2-cycle low glitch while high.
    hold(1'b0, 4);
    hold(1'b1, 12);
    hold(1'b0, 2);
    hold(1'b1, 10);

    // Fall, then a bounce pattern before settling high.
    hold(1'b0, 12);
    hold(1'b1, 1);
    hold(1'b0, 1);
    hold(1'b1, 1);
    hold(1'b0, 1);
    hold(1'b1, 12);

    // Reset mid-qualification with the input held high through release.
    hold(1'b0, 12);
    hold(1'b1, 5);
    do_reset(1);
    hold(1'b1, 12);

    // Many one-cycle low pulses while high: counter saturation.
    for (int i = 0; i < 300; i++) begin
      hold(1'b0, 1);
      hold(1'b1, 1);
    end
    hold(1'b1, 10);

    // Randomized levels and hold lengths around the threshold, with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        do_reset(int'($urandom_range(1, 3)));
      end
      hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 2 * S + 4)));
    end
    hold(1'b0, 12);

    repeat (2) @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
